// File: rtl/mips_data_register.sv
// Memory data register (MDR) for the multi-cycle MIPS datapath.
// Captures the memory read bus in the load state and holds it for write-back.
module mips_data_register #(
    parameter int unsigned          WIDTH      = 32,
    parameter int unsigned          STATE_W    = 3,
    parameter logic [STATE_W-1:0]   LOAD_STATE = 3'd3,
    parameter logic [WIDTH-1:0]     RESET_VAL  = '0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [STATE_W-1:0] state,
    input  logic [WIDTH-1:0]   dr_writedata,
    output logic [WIDTH-1:0]   dr_readdata
);

    logic [WIDTH-1:0] mdr_q;

    // Reset wins over a load in the same cycle; every other state code holds.
    always_ff @(posedge clk) begin
        if (reset) begin
            mdr_q <= RESET_VAL;
        end else if (state == LOAD_STATE) begin
            mdr_q <= dr_writedata;
        end
    end

    assign dr_readdata = mdr_q;

endmodule

// File: tb/tb_mips_data_register.sv
// Scoreboard bench for mips_data_register: driver pushes expected MDR contents,
// an independent monitor pops and compares one time unit after each posedge.
module tb_mips_data_register;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [2:0]  state = 3'd0;
    logic [31:0] dr_writedata = 32'h0;
    logic [31:0] dr_readdata;

    always #5 clk = ~clk;

    mips_data_register #(
        .WIDTH      (32),
        .STATE_W    (3),
        .LOAD_STATE (3'd3),
        .RESET_VAL  (32'h0)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .state        (state),
        .dr_writedata (dr_writedata),
        .dr_readdata  (dr_readdata)
    );

    typedef struct {
        logic [31:0] exp;
        string       tag;
    } exp_t;

    exp_t        sb[$];
    int unsigned errors = 0;
    int unsigned checks = 0;

    // Reference: the last word seen in the load state, or zero after a reset.
    logic [31:0] last_loaded = 32'h0;

    task automatic step(input logic r, input logic [2:0] s, input logic [31:0] d, input string tag);
        exp_t e;
        @(negedge clk);
        reset        = r;
        state        = s;
        dr_writedata = d;
        if (r)
            last_loaded = 32'h0;
        else if (s == 3'd3)
            last_loaded = d;
        e.exp = last_loaded;
        e.tag = tag;
        sb.push_back(e);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                checks++;
                if (dr_readdata !== e.exp) begin
                    errors++;
                    $display("FAIL %s: dr_readdata=%08h expected=%08h", e.tag, dr_readdata, e.exp);
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : driver
        logic [2:0] hold_states [7];
        hold_states = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd6, 3'd7};

        step(1'b1, 3'd3, 32'hDEADBEEF, "reset_overrides_load");
        step(1'b0, 3'd3, 32'h12345678, "load");

        step(1'b0, 3'd3, 32'hA5A5A5A5, "load_before_hold");
        foreach (hold_states[i])
            step(1'b0, hold_states[i], 32'hFFFFFFFF, $sformatf("hold_state%0d", hold_states[i]));

        step(1'b0, 3'd3, 32'h00000001, "b2b_1");
        step(1'b0, 3'd3, 32'h00000002, "b2b_2");
        step(1'b0, 3'd3, 32'h00000003, "b2b_3");

        step(1'b0, 3'd3, 32'hCAFEF00D, "load_cafef00d");
        step(1'b0, 3'd0, 32'h11111111, "hold_cafe_1");
        step(1'b0, 3'd4, 32'h22222222, "hold_cafe_2");
        step(1'b1, 3'd0, 32'h33333333, "reset_mid_hold");
        step(1'b0, 3'd0, 32'h44444444, "zero_after_reset_1");
        step(1'b0, 3'd7, 32'h55555555, "zero_after_reset_2");
        step(1'b0, 3'd3, 32'h80000001, "full_width_load");

        for (int i = 0; i < 300; i++) begin
            logic        r;
            logic [2:0]  s;
            logic [31:0] d;
            r = ($urandom_range(0, 99) == 0);
            s = 3'($urandom_range(0, 5));
            d = $urandom;
            step(r, s, d, $sformatf("soak_%0d", i));
        end

        repeat (3) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: pending=%0d expected=0", sb.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
